wb_stage: RTL
=============

Name: wb_stage

Overview:
Writeback stage between the memory-access stage and the register file write port. Accepts one retiring instruction per handshake and selects the writeback source: ALU result, formatted load data, or PC+4. For loads it waits for the data-memory read response and sign/zero-extends it. It drives registered write_address/write_data/RegWrite to the register file, and these outputs double as the EX-stage forwarding source. It also keeps a retired-instruction counter and a sticky load-timeout error flag.

Parameters:
LOAD_TIMEOUT, 16, maximum number of cycles spent in WAIT_LOAD before abort; 0 disables the timeout.
CNT_W, 16, width of the load wait counter (must hold LOAD_TIMEOUT).

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
in_valid  input  1  MEM stage presents an instruction
in_ready  output  1  stage can accept this cycle
in_rd  input  5  destination register
in_regwrite  input  1  instruction writes rd
in_wbsel  input  2  00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU)
in_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
in_alu_result  input  32  ALU result; load address for loads
in_pc_plus4  input  32  PC+4 of the instruction
mem_rvalid  input  1  load data valid, single-cycle pulse
mem_rdata  input  32  raw 32-bit aligned word
write_address  output  5  to register file
write_data  output  32  to register file
RegWrite  output  1  register file write enable
busy  output  1  high in WAIT_LOAD
instret  output  32  retired instruction count
load_err  output  1  sticky load-timeout flag

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; write_address=0, write_data=0, RegWrite=0, busy=0, instret=0, load_err=0, wait counter=0. Reset asserted mid-load aborts the load with no write. After release, in_ready=1.
- All outputs are registered. in_ready is combinational: 1 in IDLE and WRITE, 0 in WAIT_LOAD.
- Accept occurs when in_valid & in_ready at a rising edge. Captured fields: rd, regwrite, wbsel, funct3, alu_result, pc_plus4.
- State IDLE: on accept with wbsel=01, go to WAIT_LOAD and clear the counter. On any other accept, go to WRITE and load the outputs. With no accept, stay in IDLE.
- State WAIT_LOAD: the counter increments each cycle.
  - On mem_rvalid, load the formatted data into the outputs and go to WRITE.
  - Otherwise, if LOAD_TIMEOUT!=0 and counter reaches LOAD_TIMEOUT-1, set load_err=1, go to IDLE, do not write, and do not increment instret.
  - mem_rvalid takes priority over timeout in the same cycle.
- State WRITE: RegWrite=1 for exactly this one cycle when captured regwrite=1 and rd!=0. write_address=rd. write_data is the selected value. instret increments by 1 on entering WRITE (including regwrite=0 and rd=0 cases).
  - A new accept in WRITE follows the IDLE transition rules, giving back-to-back throughput of 1 instruction/cycle for non-loads. Otherwise return to IDLE.
- Outside WRITE, RegWrite=0. write_address/write_data hold their last values.
- Latency: for non-loads, accept at edge N gives RegWrite high in the cycle after edge N. For loads, mem_rvalid sampled at edge M gives RegWrite high in the cycle after edge M.
- mem_rvalid outside WAIT_LOAD is ignored.
- Load formatting uses offset = alu_result[1:0]:
  - LB/LBU: byte = rdata[8*offset+7 : 8*offset].
  - LH/LHU: half = offset[1] ? rdata[31:16] : rdata[15:0]; offset[0] is ignored.
  - LW: rdata, offset ignored.
  - LB/LH sign-extend; LBU/LHU zero-extend. Undefined funct3 is treated as LW.
- instret wraps from 0xFFFFFFFF to 0. load_err clears only on reset.

Test Plan:
1. Reset: hold reset=0 for 3 cycles, then release -> all outputs 0, in_ready=1. Assert reset=0 during WAIT_LOAD -> no RegWrite pulse, state IDLE, instret unchanged.
2. ALU op, rd=5, alu_result=0x12345678, regwrite=1 -> next cycle RegWrite=1, write_address=5, write_data=0x12345678, instret=1. Three back-to-back ALU ops -> three consecutive RegWrite pulses, in_ready stays 1.
3. Load LB, alu_result=0x1002, mem_rdata=0x80FF7F01 -> write_data=0xFFFFFFFF. LBU, same inputs -> 0x000000FF. LH offset 2 -> 0xFFFF80FF. LHU offset 0 -> 0x00007F01. LW -> 0x80FF7F01.
4. Load with mem_rvalid 3 cycles after accept -> busy=1 and in_ready=0 for those cycles. RegWrite occurs the cycle after rvalid. A new in_valid held during the wait is accepted only in the WRITE cycle.
5. LOAD_TIMEOUT=4, no mem_rvalid -> load_err=1 after 4 WAIT_LOAD cycles, no RegWrite, instret unchanged, return to IDLE. A late mem_rvalid afterwards is ignored.
6. ALU op with rd=0 and regwrite=1, then PC+4 op with rd=1, pc_plus4=0x00000104 -> first produces RegWrite=0 but instret increments. Second gives RegWrite=1, write_address=1, write_data=0x00000104.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: picks the value that retires into the register file
// (ALU result, formatted load data or PC+4), waits on the data memory for
// loads, counts retired instructions and flags loads that never return.
module wb_stage #(
  parameter int LOAD_TIMEOUT = 16,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_regwrite,
  input  logic [1:0]  in_wbsel,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_pc_plus4,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  write_address,
  output logic [31:0] write_data,
  output logic        RegWrite,
  output logic        busy,
  output logic [31:0] instret,
  output logic        load_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    WRITE     = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [4:0]       ld_rd;
  logic             ld_regwrite;
  logic [2:0]       ld_funct3;
  logic [1:0]       ld_offset;

  logic             accept;
  logic             timeout_hit;
  logic [31:0]      direct_data;
  logic [31:0]      load_data;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;

  // Only a pending load blocks the MEM stage; WRITE can take the next instruction.
  always_comb begin
    in_ready    = (state != WAIT_LOAD);
    accept      = in_valid && in_ready;
    timeout_hit = (LOAD_TIMEOUT != 0) && (wait_cnt == TIMEOUT_LAST);
    direct_data = (in_wbsel == 2'b10) ? in_pc_plus4 : in_alu_result;
  end

  // Extract and extend the addressed byte/half of the returned word; unknown funct3 behaves as LW.
  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (ld_offset)
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      2'd3:    byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = ld_offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_funct3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  // Stage FSM; every output is registered here so it can feed EX forwarding directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      ld_rd         <= '0;
      ld_regwrite   <= 1'b0;
      ld_funct3     <= '0;
      ld_offset     <= '0;
      write_address <= '0;
      write_data    <= '0;
      RegWrite      <= 1'b0;
      busy          <= 1'b0;
      instret       <= '0;
      load_err      <= 1'b0;
    end else begin
      case (state)
        IDLE, WRITE: begin
          if (accept) begin
            if (in_wbsel == 2'b01) begin
              state       <= WAIT_LOAD;
              wait_cnt    <= '0;
              ld_rd       <= in_rd;
              ld_regwrite <= in_regwrite;
              ld_funct3   <= in_funct3;
              ld_offset   <= in_alu_result[1:0];
              RegWrite    <= 1'b0;
              busy        <= 1'b1;
            end else begin
              state         <= WRITE;
              write_address <= in_rd;
              write_data    <= direct_data;
              RegWrite      <= in_regwrite && (in_rd != 5'd0);
              instret       <= instret + 32'd1;
              busy          <= 1'b0;
            end
          end else begin
            state    <= IDLE;
            RegWrite <= 1'b0;
            busy     <= 1'b0;
          end
        end
        WAIT_LOAD: begin
          if (mem_rvalid) begin
            state         <= WRITE;
            write_address <= ld_rd;
            write_data    <= load_data;
            RegWrite      <= ld_regwrite && (ld_rd != 5'd0);
            instret       <= instret + 32'd1;
            busy          <= 1'b0;
          end else if (timeout_hit) begin
            state    <= IDLE;
            load_err <= 1'b1;
            busy     <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          RegWrite <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
